// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_animator
//  Description : Scan-position to sprite-ROM address mapper with integer
//                scaling, horizontal flip, frame-synchronous position
//                shadowing and a one-shot / looping animation sequencer.
//                Two-stage pipeline: address stage, then palette-index stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_animator #(
  parameter int SPRITE_W        = 196,
  parameter int SPRITE_H        = 96,
  parameter int NUM_FRAMES      = 3,
  parameter int IDX_W           = 3,
  parameter int SCALE_SHIFT     = 0,
  parameter int FRAME_HOLD      = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              flip_x,
  input  logic              anim_start,
  input  logic              anim_loop,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit,
  output logic              pix_blank,
  output logic              anim_busy,
  output logic              anim_done,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] anim_frame
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  // On-screen span; 11 bits so pos + span never wraps for any 10-bit pos.
  localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_SHIFT);
  localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_SHIFT);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] frame_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic               done_n;

  logic [9:0]  pos_x, pos_y;
  logic        flip;
  logic        in_range;
  logic        in_range_d;
  logic        blank_d;
  logic [10:0] end_x, end_y;
  logic [9:0]  dx, dy;
  logic [31:0] lx, ly, addr_calc;

  // Shadow the requested placement once per video frame so motion never tears.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pos_x <= '0;
      pos_y <= '0;
      flip  <= 1'b0;
    end else if (frame_start) begin
      pos_x <= sprite_x;
      pos_y <= sprite_y;
      flip  <= flip_x;
    end
  end

  // Hit test and sprite-local coordinate / ROM address computation.
  always_comb begin
    end_x    = {1'b0, pos_x} + SPAN_X;
    end_y    = {1'b0, pos_y} + SPAN_Y;
    in_range = (DrawX >= pos_x) && ({1'b0, DrawX} < end_x) &&
               (DrawY >= pos_y) && ({1'b0, DrawY} < end_y);
    dx = DrawX - pos_x;
    dy = DrawY - pos_y;
    lx = 32'(dx >> SCALE_SHIFT);
    ly = 32'(dy >> SCALE_SHIFT);
    if (flip) begin
      lx = 32'(SPRITE_W - 1) - lx;
    end
    addr_calc = 32'(anim_frame) * 32'(SPRITE_W * SPRITE_H)
              + ly * 32'(SPRITE_W) + lx;
  end

  // Stage 1: register ROM address and the flags that travel with it.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      in_range_d  <= 1'b0;
      blank_d     <= 1'b0;
    end else begin
      rom_address <= in_range ? addr_calc[ADDR_W-1:0] : '0;
      in_range_d  <= in_range;
      blank_d     <= blank;
    end
  end

  // Stage 2: capture ROM data and qualify the hit against transparency.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_idx   <= '0;
      pix_hit   <= 1'b0;
      pix_blank <= 1'b0;
    end else begin
      pix_idx   <= rom_q;
      pix_hit   <= in_range_d && (rom_q != IDX_W'(TRANSPARENT_IDX));
      pix_blank <= blank_d;
    end
  end

  // Animation state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      anim_frame <= '0;
      hold       <= '0;
      anim_done  <= 1'b0;
    end else begin
      state      <= state_n;
      anim_frame <= frame_n;
      hold       <= hold_n;
      anim_done  <= done_n;
    end
  end

  // Animation next-state: restart beats frame advance; loop sampled at wrap.
  always_comb begin
    state_n = state;
    frame_n = anim_frame;
    hold_n  = hold;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        frame_n = '0;
        hold_n  = '0;
        if (anim_start) begin
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (anim_start) begin
          frame_n = '0;
          hold_n  = '0;
        end else if (frame_start) begin
          if (hold != LAST_HOLD) begin
            hold_n = hold + HOLD_W'(1);
          end else begin
            hold_n = '0;
            if (anim_frame != LAST_FRAME) begin
              frame_n = anim_frame + FRAME_W'(1);
            end else if (anim_loop) begin
              frame_n = '0;
            end else begin
              frame_n = '0;
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        frame_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  assign anim_busy = (state == PLAY);

endmodule
`default_nettype wire

// File: doc/sprite_animator.md
# sprite_animator

Parametrised sprite renderer for the VGA pipeline. It maps the scan position onto a multi-frame sprite ROM at a programmable screen position, with integer scaling and horizontal flip. A frame-synchronous animation FSM supports one-shot and looped playback. It drives the address of an external synchronous sprite ROM and emits a registered palette index plus hit/blank flags for the downstream colour mux and palette.

## Interface
Parameters:
- SPRITE_W, 196, sprite width in pixels (per animation frame)
- SPRITE_H, 96, sprite height in pixels
- NUM_FRAMES, 3, animation frames stored back-to-back in ROM (≥1)
- IDX_W, 3, palette index width of ROM data
- SCALE_SHIFT, 0, on-screen scale factor 2^SCALE_SHIFT in both axes
- FRAME_HOLD, 4, frame_start pulses per animation frame (≥1)
- TRANSPARENT_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES), ROM address width (16 at defaults)

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- DrawX, DrawY  in  10 each  current scan coordinate
- blank  in  1  1 = active video (display enable)
- frame_start  in  1  one-cycle pulse, once per video frame, outside active video
- sprite_x, sprite_y  in  10 each  requested top-left screen position
- flip_x  in  1  requested horizontal mirror
- anim_start  in  1  pulse: start or restart playback from frame 0
- anim_loop  in  1  1 = wrap after last frame; 0 = one-shot
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- pix_idx  out  IDX_W  registered palette index
- pix_hit  out  1  sprite covers pixel and index is not transparent
- pix_blank  out  1  blank delayed to align with pix_idx
- anim_busy  out  1  FSM in PLAY
- anim_done  out  1  one-cycle pulse when a one-shot completes
- anim_frame  out  $clog2(NUM_FRAMES) min 1  current frame number

## Operation
- Shadow registers pos_x, pos_y and flip load from sprite_x, sprite_y and flip_x only on frame_start. Motion therefore never tears mid-frame.
- Span: SW = SPRITE_W<<SCALE_SHIFT, SH = SPRITE_H<<SCALE_SHIFT. Compute in 11 bits to avoid overflow.
- in_range = DrawX ≥ pos_x, DrawX < pos_x+SW, DrawY ≥ pos_y, DrawY < pos_y+SH. Off-left and off-top placement is not supported. Off-right and off-bottom are clipped naturally.
- Local coordinates: lx = (DrawX−pos_x)>>SCALE_SHIFT; ly = (DrawY−pos_y)>>SCALE_SHIFT. If flip = 1, lx = SPRITE_W−1−lx.
- Address = anim_frame*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx. When in_range = 0 the address is 0.
- pix_hit = delayed in_range AND rom_q ≠ TRANSPARENT_IDX. pix_idx = rom_q unconditionally.
- Animation FSM, states IDLE and PLAY:
  - In IDLE: anim_frame = 0, hold counter = 0.
  - IDLE, anim_start → PLAY with frame 0, hold 0. A frame_start in the same cycle is not counted.
  - PLAY, on frame_start with hold < FRAME_HOLD−1: hold++.
  - PLAY, on frame_start with hold = FRAME_HOLD−1: hold resets to 0.
    - If frame < NUM_FRAMES−1: frame++.
    - Else if anim_loop: frame = 0, stay in PLAY.
    - Else: → IDLE, frame = 0, anim_done pulses for one cycle.
  - PLAY, anim_start: restart (frame 0, hold 0). This takes priority over a coincident frame_start.
  - anim_loop is sampled only at the last-frame boundary. Deasserting it lets the current pass finish.
- anim_frame changes only on frame_start edges or anim_start, so it is stable across active video.

## Timing
- Reset values: all outputs are 0, state is IDLE, and shadow registers and counters are 0.
- Stage 1, at edge k: rom_address, in_range_d and blank_d register from DrawX, DrawY and blank of cycle k.
- The ROM returns rom_q during cycle k+1.
- Stage 2, at edge k+1: pix_idx, pix_hit and pix_blank register.
- Total latency from DrawX/DrawY to pix_* is 2 cycles. Throughput is one pixel per cycle with no stalls.
- anim_busy and anim_frame update on the edge that samples frame_start or anim_start.
- anim_done is high for the single cycle after the terminating edge. anim_busy falls on that same edge.
- Reset asserted mid-play returns the FSM to IDLE immediately (asynchronous). No anim_done is generated.

## Test plan
- Addressing, position (100,50) at defaults: DrawX/DrawY = (100,50) → rom_address 0 one edge later. (295,145) → 18815 with in-range. (296,50) → address 0, pix_hit 0 after two edges.
- Flip and frame: flip_x = 1 latched, anim_frame = 2. DrawX/DrawY = (100,50) → rom_address 37632+195 = 37827.
- Transparency: in range with rom_q = 0 → pix_hit 0. With rom_q = 5 → pix_idx 5, pix_hit 1, pix_blank equal to blank delayed 2 cycles.
- One-shot: anim_start, then 12 frame_start pulses → anim_frame steps 0,1,2 every 4 pulses. anim_done pulses once after the 12th pulse and anim_busy falls. With anim_loop = 1, the 12th pulse returns the frame to 0 and anim_busy stays high.
- Shadowing and scale: change sprite_x mid-frame → address unchanged until frame_start. With SCALE_SHIFT = 1 and pos (0,0), DrawX = 3 → lx 1, address 1.
- Reset mid-play: assert reset at frame 1 → all outputs 0 asynchronously. No anim_done. After release, the next anim_start plays from frame 0.
